// File: rtl/formatare_iesire.sv
// Output formatter: Enigma letter pulses -> uppercase ASCII FIFO -> valid/ready byte stream for the UART.
// Define FORMATARE_GRUPE_EN to split the output into GROUP_LEN-letter groups separated by spaces.
module formatare_iesire #(
  parameter int FIFO_DEPTH = 16,
  parameter int GROUP_LEN  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          valid_in,
  input  logic [4:0]                    char_in,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 4");
  end
  if (GROUP_LEN < 1 || GROUP_LEN > 31) begin : g_glen_chk
    $error("GROUP_LEN must be in 1..31");
  end

  typedef enum logic {OUT_EMPTY, OUT_HOLD} out_state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  out_state_e    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          push_req, push_ok, pop, load_en, fifo_empty, full, insert_space;

`ifdef FORMATARE_GRUPE_EN
  localparam logic [4:0] GRP_C = 5'(GROUP_LEN);
  logic [4:0] grp_cnt_q, grp_cnt_d;
`endif

  // Full/empty are judged on occupancy at the start of the cycle, so a push while full drops even if a pop happens too.
  always_comb begin
    push_req   = valid_in && (char_in <= 5'd25);
    full       = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    push_ok    = push_req && !full;
    wr_data    = 8'h41 + {3'b000, char_in};
    load_en    = (state_q == OUT_EMPTY) || tx_ready;
`ifdef FORMATARE_GRUPE_EN
    insert_space = load_en && !fifo_empty && (grp_cnt_q == GRP_C);
`else
    insert_space = 1'b0;
`endif
    pop = load_en && !fifo_empty && !insert_space;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
`ifdef FORMATARE_GRUPE_EN
    grp_cnt_d  = grp_cnt_q;
`endif
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      state_d    = OUT_EMPTY;
      overflow_d = 1'b0;
`ifdef FORMATARE_GRUPE_EN
      grp_cnt_d  = '0;
`endif
    end else begin
      if (push_ok) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (push_req && full) begin
        overflow_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      // A space holds the pending letter back in the FIFO; it loads at the next opportunity.
      if (load_en) begin
        if (insert_space) begin
          data_d  = 8'h20;
          state_d = OUT_HOLD;
`ifdef FORMATARE_GRUPE_EN
          grp_cnt_d = '0;
`endif
        end else if (pop) begin
          data_d  = mem_q[rd_ptr_q];
          state_d = OUT_HOLD;
`ifdef FORMATARE_GRUPE_EN
          grp_cnt_d = grp_cnt_q + 5'd1;
`endif
        end else begin
          state_d = OUT_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= OUT_EMPTY;
      data_q     <= 8'h00;
      overflow_q <= 1'b0;
`ifdef FORMATARE_GRUPE_EN
      grp_cnt_q  <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
`ifdef FORMATARE_GRUPE_EN
      grp_cnt_q  <= grp_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign tx_valid  = (state_q == OUT_HOLD);
  assign tx_data   = data_q;
  assign fifo_full = full;
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_formatare_iesire.sv
// Directed self-checking bench for formatare_iesire; expected byte streams honour FORMATARE_GRUPE_EN.
module tb_formatare_iesire;

  localparam int DEPTH = 16;
  localparam int GLEN  = 5;

  logic       clk = 1'b0;
  logic       rst_n, clear, valid_in, tx_ready;
  logic [4:0] char_in;
  logic       tx_valid, fifo_full, overflow;
  logic [7:0] tx_data;
  logic [4:0] count;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_bytes [64];
  logic [7:0] got_bytes [64];
  int         exp_len, got_len;

  always #5 clk = ~clk;

  formatare_iesire #(.FIFO_DEPTH(DEPTH), .GROUP_LEN(GLEN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .char_in(char_in),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_full(fifo_full), .overflow(overflow), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] c);
    valid_in = v;
    char_in  = c;
    tick();
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    valid_in = 1'b0;
    tick();
    clear    = 1'b0;
  endtask

  // Reference byte stream: letters from 'first', a space before every GLEN-th+1 letter when grouping is on.
  task automatic build_expected(input int first, input int n);
    int grp;
    grp     = 0;
    exp_len = 0;
    for (int i = 0; i < n; i++) begin
`ifdef FORMATARE_GRUPE_EN
      if (grp == GLEN) begin
        exp_bytes[exp_len] = 8'h20;
        exp_len++;
        grp = 0;
      end
`endif
      exp_bytes[exp_len] = 8'(8'h41 + first + i);
      exp_len++;
      grp++;
    end
  endtask

  task automatic record_byte();
    if (tx_valid && tx_ready && got_len < 64) begin
      got_bytes[got_len] = tx_data;
      got_len++;
    end
  endtask

  task automatic collect(input int cycles);
    tx_ready = 1'b1;
    valid_in = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      record_byte();
      tick();
    end
  endtask

  task automatic reset_got();
    got_len = 0;
    for (int k = 0; k < 64; k++) got_bytes[k] = 8'h00;
  endtask

  task automatic compare_stream(input string tag);
    check_output({tag, "_len"}, 32'(got_len), 32'(exp_len));
    for (int k = 0; k < exp_len; k++) begin
      check_output($sformatf("%s_byte%0d", tag, k), {24'h0, got_bytes[k]}, {24'h0, exp_bytes[k]});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    valid_in = 1'b1;
    char_in  = 5'd3;
    tx_ready = 1'b0;
    repeat (3) tick();
    check_output("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_output("rst_tx_data", 32'(tx_data), 32'h00);
    check_output("rst_fifo_full", 32'(fifo_full), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    tick();
    check_output("post_rst_count", 32'(count), 32'd0);
    check_output("post_rst_tx_valid", 32'(tx_valid), 32'd0);

    $display("[TB] ordering and latency");
    tx_ready = 1'b1;
    apply_stimulus(1'b1, 5'd0);
    check_output("lat_n1_tx_valid", 32'(tx_valid), 32'd0);
    check_output("lat_n1_count", 32'(count), 32'd1);
    apply_stimulus(1'b1, 5'd25);
    check_output("lat_n2_tx_valid", 32'(tx_valid), 32'd1);
    check_output("ord_byte0", 32'(tx_data), 32'h41);
    apply_stimulus(1'b1, 5'd7);
    check_output("ord_byte1", 32'(tx_data), 32'h5A);
    apply_stimulus(1'b0, 5'd0);
    check_output("ord_byte2", 32'(tx_data), 32'h48);
    check_output("ord_byte2_valid", 32'(tx_valid), 32'd1);
    apply_stimulus(1'b0, 5'd0);
    check_output("ord_idle_valid", 32'(tx_valid), 32'd0);
    check_output("ord_idle_count", 32'(count), 32'd0);

    $display("[TB] grouping stream");
    do_clear();
    tx_ready = 1'b1;
    reset_got();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 12) begin
        valid_in = 1'b1;
        char_in  = 5'(cyc);
      end else begin
        valid_in = 1'b0;
      end
      record_byte();
      tick();
    end
    build_expected(0, 12);
    compare_stream("grp");
    check_output("grp_idle_valid", 32'(tx_valid), 32'd0);

    $display("[TB] overflow and backpressure");
    do_clear();
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 5'(i));
    check_output("ovf17_full", 32'(fifo_full), 32'd1);
    check_output("ovf17_count", 32'(count), 32'd16);
    check_output("ovf17_overflow", 32'(overflow), 32'd0);
    apply_stimulus(1'b1, 5'd17);
    check_output("ovf18_overflow", 32'(overflow), 32'd1);
    check_output("ovf18_full", 32'(fifo_full), 32'd1);
    check_output("ovf18_tx_data", 32'(tx_data), 32'h41);
    check_output("ovf18_count", 32'(count), 32'd16);
    reset_got();
    collect(40);
    build_expected(0, 17);
    compare_stream("drain");
    check_output("drain_overflow_sticky", 32'(overflow), 32'd1);
    check_output("drain_count", 32'(count), 32'd0);

    $display("[TB] clear mid-stream");
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 5'(i));
    check_output("clr_pre_count", 32'(count), 32'd6);
    check_output("clr_pre_valid", 32'(tx_valid), 32'd1);
    clear    = 1'b1;
    valid_in = 1'b1;
    char_in  = 5'd9;
    tick();
    clear    = 1'b0;
    valid_in = 1'b0;
    check_output("clr_tx_valid", 32'(tx_valid), 32'd0);
    check_output("clr_count", 32'(count), 32'd0);
    check_output("clr_overflow", 32'(overflow), 32'd0);
    tick();
    check_output("clr_push_discarded", 32'(count), 32'd0);
    check_output("clr_still_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b1;
    reset_got();
    valid_in = 1'b1;
    char_in  = 5'd9;
    record_byte();
    tick();
    collect(6);
    build_expected(9, 1);
    compare_stream("after_clr");

    $display("[TB] invalid letters");
    do_clear();
    tx_ready = 1'b0;
    apply_stimulus(1'b1, 5'd0);
    apply_stimulus(1'b1, 5'd1);
    check_output("inv_base_count", 32'(count), 32'd1);
    apply_stimulus(1'b1, 5'd26);
    check_output("inv26_count", 32'(count), 32'd1);
    apply_stimulus(1'b1, 5'd31);
    check_output("inv31_count", 32'(count), 32'd1);
    check_output("inv_overflow", 32'(overflow), 32'd0);
    check_output("inv_tx_data", 32'(tx_data), 32'h41);

    $display("[TB] push while full with simultaneous pop");
    do_clear();
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 5'(i));
    check_output("simul_pre_count", 32'(count), 32'd16);
    check_output("simul_pre_overflow", 32'(overflow), 32'd0);
    tx_ready = 1'b1;
    apply_stimulus(1'b1, 5'd20);
    check_output("simul_count", 32'(count), 32'd15);
    check_output("simul_overflow", 32'(overflow), 32'd1);
    check_output("simul_tx_data", 32'(tx_data), 32'h42);
    check_output("simul_full", 32'(fifo_full), 32'd0);
    valid_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
